apb_bridge_arbiter: RTL and testbench
=====================================

Name: apb_bridge_arbiter

Overview:
- Engine-side controller for the AXI2APB bridge. It sits between the AXI read slave, the AXI write slave and the shared APB master.
- Arbitrates round-robin between pending read and write transactions and commands the APB master (READ/WRITE, then DISABLE once it reports SWITCH).
- Accumulates PSLVERR per transaction and reports completion with a response status to the winning AXI side.
- Runs a watchdog on stalled APB transfers.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before watchdog flag asserts; must be >= 2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  AXI read slave has a captured read address and read FIFO space; held until rd_grant
- wr_req  in  1  AXI write slave has address and all write beats in FIFO; held until wr_grant
- rd_grant  out  1  one-cycle pulse: read transaction issued to APB master
- wr_grant  out  1  one-cycle pulse: write transaction issued to APB master
- rd_done  out  1  level: read transaction complete, held until resp_ack
- wr_done  out  1  level: write transaction complete, held until resp_ack
- resp_err  out  1  valid with rd_done/wr_done: 1 = at least one beat had PSLVERR (SLVERR)
- resp_ack  in  1  AXI side accepted the response (R last / B handshake)
- apb_cmd  out  2  to APB master: 00 IDLE, 01 READ, 10 WRITE, 11 DISABLE
- apb_info  in  2  from APB master: 00 IDLE, 01 BUSY, 10 SWITCH
- apb_err_beat  in  1  pslverr & penable & pready, one per completed beat
- wd_timeout  out  1  sticky: a transfer exceeded TIMEOUT_CYCLES in WAIT; cleared only by reset
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All outputs 0; apb_cmd=00.
  - State IDLE; last_served=WRITE, so a read wins the first tie.
  - Error accumulator and watchdog counter 0.
- State machine (registered state; outputs decoded from registered state):
  - IDLE:
    - Evaluate requests only when apb_info==00.
    - Only one requester asserted: grant it.
    - Both asserted: grant the opposite of last_served.
    - On grant: latch access type, update last_served, clear the error accumulator and watchdog counter, go ISSUE.
    - No request: stay.
  - ISSUE (exactly 1 cycle): apb_cmd=READ or WRITE; rd_grant/wr_grant pulse high this cycle; go WAIT.
  - WAIT:
    - apb_cmd=IDLE.
    - err_acc |= apb_err_beat each cycle.
    - Watchdog counter increments, saturating at TIMEOUT_CYCLES; wd_timeout sets when the counter reaches TIMEOUT_CYCLES.
    - On apb_info==SWITCH: go RELEASE. No abort on timeout.
  - RELEASE:
    - apb_cmd=DISABLE; still OR in apb_err_beat.
    - Stay until apb_info==IDLE, then go RESP. Nominally 2 cycles: master leaves DONE on the next edge.
  - RESP:
    - rd_done or wr_done high per latched type; resp_err=err_acc; apb_cmd=IDLE.
    - On resp_ack: go IDLE.
    - New arbitration at the earliest on the cycle after ack.
- Latency, from rd_req/wr_req high with master idle:
  - Grant pulse 1 cycle later (ISSUE).
  - Master reports BUSY 1 cycle after ISSUE.
  - done asserts 2 cycles after apb_info first reads SWITCH.
- Boundary conditions:
  - A request arriving during a transaction is held by the requester and served next.
  - Alternating ties give strict R/W/R/W.
  - A single requester may be served back-to-back; last_served does not block it.
  - resp_ack outside RESP is ignored.
  - apb_info==SWITCH seen in IDLE/ISSUE is ignored.
  - A request deasserting before grant is a requester protocol violation; the arbiter does not need to handle it.
  - The grant pulse never coincides with done.
  - Asynchronous reset mid-transaction returns to IDLE with cmd=00 immediately. The APB master shares the reset, so no DISABLE is needed.
  - wd_timeout is not cleared by transaction completion.

Test Plan:
- Single read: rd_req=1, apb_info IDLE→BUSY (cycle 2)→SWITCH (cycle 6)→IDLE (cycle 8) → apb_cmd=01 in cycle 1, rd_grant pulse cycle 1, DISABLE cycles 6-7, rd_done=1 from cycle 8 until resp_ack, resp_err=0.
- Tie after reset: rd_req=wr_req=1 continuously, 4 transactions → grant order R,W,R,W.
- Error accumulation: 4-beat write, apb_err_beat=1 on beat 3 only → wr_done with resp_err=1; next transaction with no errors → resp_err=0.
- Response back-pressure: hold resp_ack=0 for 10 cycles with wr_req pending → no new grant and apb_cmd=00 throughout; grant 2 cycles after ack (IDLE then ISSUE).
- Watchdog: TIMEOUT_CYCLES=8, apb_info held BUSY for 20 cycles → wd_timeout rises on the 8th WAIT cycle, stays 1 after normal completion and through the next transaction.
- Reset mid-WAIT: assert rst_n=0 → all outputs 0 asynchronously; after release, pending rd_req is granted normally.

Source files
------------

// File: rtl/apb_bridge_arbiter_if.sv
// ----------------------------------------------------------------------------
// apb_bridge_arbiter_if
// Bundles the handshake signals between the AXI2APB arbiter, the AXI read and
// write slaves, and the shared APB master.
//   master modport : the arbiter itself (drives grants, done, cmd, status)
//   slave  modport : the surrounding AXI slaves / APB master
// Signals:
//   rd_req, wr_req       AXI side has a transaction ready (held until grant)
//   rd_grant, wr_grant   one-cycle grant pulse
//   rd_done, wr_done     completion level, held until resp_ack
//   resp_err             SLVERR status, valid with rd_done/wr_done
//   resp_ack             AXI side accepted the response
//   apb_cmd[1:0]         00 IDLE, 01 READ, 10 WRITE, 11 DISABLE
//   apb_info[1:0]        00 IDLE, 01 BUSY, 10 SWITCH
//   apb_err_beat         PSLVERR on a completed APB beat
//   wd_timeout           sticky watchdog flag
//   busy                 arbiter not idle
// ----------------------------------------------------------------------------
interface apb_bridge_arbiter_if;
    logic       rd_req;
    logic       wr_req;
    logic       rd_grant;
    logic       wr_grant;
    logic       rd_done;
    logic       wr_done;
    logic       resp_err;
    logic       resp_ack;
    logic [1:0] apb_cmd;
    logic [1:0] apb_info;
    logic       apb_err_beat;
    logic       wd_timeout;
    logic       busy;

    modport master (
        input  rd_req, wr_req, resp_ack, apb_info, apb_err_beat,
        output rd_grant, wr_grant, rd_done, wr_done, resp_err,
               apb_cmd, wd_timeout, busy
    );

    modport slave (
        output rd_req, wr_req, resp_ack, apb_info, apb_err_beat,
        input  rd_grant, wr_grant, rd_done, wr_done, resp_err,
               apb_cmd, wd_timeout, busy
    );
endinterface

// File: rtl/apb_bridge_arbiter.sv
// ----------------------------------------------------------------------------
// apb_bridge_arbiter
// Engine-side controller of the AXI2APB bridge. Round-robin arbitrates between
// pending AXI reads and writes, commands the shared APB master, accumulates
// PSLVERR across the beats of a transaction and watches for stalled transfers.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    apb_bridge_arbiter_if.master (see interface file for signals)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a request while the APB master is idle
// S_ISSUE   | one cycle: READ/WRITE command out, grant pulse to the winner
// S_WAIT    | APB transfer in flight; OR in errors, run watchdog
// S_RELEASE | DISABLE out until the master returns to IDLE
// S_RESP    | done + resp_err held until the AXI side acknowledges
// ----------------------------------------------------------------------------
module apb_bridge_arbiter #(
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apb_bridge_arbiter_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_RESP
    } state_t;

    localparam logic [1:0] CMD_IDLE    = 2'b00;
    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_DISABLE = 2'b11;

    localparam logic [1:0] INFO_IDLE   = 2'b00;
    localparam logic [1:0] INFO_SWITCH = 2'b10;

    localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic             r_last_wr;     // 1 = last served was a write
    logic             r_is_wr;
    logic             r_err_acc;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_wd_timeout;
    logic             r_rd_grant;
    logic             r_wr_grant;
    logic             r_rd_done;
    logic             r_wr_done;
    logic             r_resp_err;
    logic [1:0]       r_cmd;
    logic             r_busy;

    logic             w_pick_rd;
    logic             w_pick_wr;
    logic             w_can_arb;

    // On a tie the side that was not served last wins.
    assign w_pick_rd = bus.rd_req & (~bus.wr_req | r_last_wr);
    assign w_pick_wr = bus.wr_req & (~bus.rd_req | ~r_last_wr);
    assign w_can_arb = (bus.apb_info == INFO_IDLE) & (bus.rd_req | bus.wr_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_wr    <= 1'b1;
            r_is_wr      <= 1'b0;
            r_err_acc    <= 1'b0;
            r_wd_cnt     <= '0;
            r_wd_timeout <= 1'b0;
            r_rd_grant   <= 1'b0;
            r_wr_grant   <= 1'b0;
            r_rd_done    <= 1'b0;
            r_wr_done    <= 1'b0;
            r_resp_err   <= 1'b0;
            r_cmd        <= CMD_IDLE;
            r_busy       <= 1'b0;
        end else begin
            r_rd_grant <= 1'b0;
            r_wr_grant <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_can_arb) begin
                        r_is_wr    <= w_pick_wr;
                        r_last_wr  <= w_pick_wr;
                        r_err_acc  <= 1'b0;
                        r_wd_cnt   <= '0;
                        r_rd_grant <= w_pick_rd;
                        r_wr_grant <= w_pick_wr;
                        r_cmd      <= w_pick_wr ? CMD_WRITE : CMD_READ;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cmd   <= CMD_IDLE;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_err_acc <= r_err_acc | bus.apb_err_beat;
                    if (r_wd_cnt != WD_MAX) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                    // Flag rises together with the counter reaching the limit.
                    if (r_wd_cnt == WD_LAST) begin
                        r_wd_timeout <= 1'b1;
                    end
                    if (bus.apb_info == INFO_SWITCH) begin
                        r_cmd   <= CMD_DISABLE;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_err_acc <= r_err_acc | bus.apb_err_beat;
                    if (bus.apb_info == INFO_IDLE) begin
                        r_cmd      <= CMD_IDLE;
                        r_rd_done  <= ~r_is_wr;
                        r_wr_done  <= r_is_wr;
                        r_resp_err <= r_err_acc | bus.apb_err_beat;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ack) begin
                        r_rd_done  <= 1'b0;
                        r_wr_done  <= 1'b0;
                        r_resp_err <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_cmd   <= CMD_IDLE;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_grant   = r_rd_grant;
    assign bus.wr_grant   = r_wr_grant;
    assign bus.rd_done    = r_rd_done;
    assign bus.wr_done    = r_wr_done;
    assign bus.resp_err   = r_resp_err;
    assign bus.apb_cmd    = r_cmd;
    assign bus.wd_timeout = r_wd_timeout;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_bridge_arbiter
// Directed bench for apb_bridge_arbiter. Stimulus pushes expected grants and
// responses into queues; a monitor pops and compares them when the arbiter
// presents a grant or a done. A small APB master model answers commands.
// ----------------------------------------------------------------------------
module tb_apb_bridge_arbiter;
    localparam int TMO = 8;

    logic clk;
    logic rst_n;

    apb_bridge_arbiter_if bus_if ();

    apb_bridge_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    int exp_g[$];   // expected grant: 0 = read, 1 = write
    int exp_r[$];   // expected response: is_write*2 + resp_err

    int cfg_len    = 4;   // BUSY cycles before SWITCH
    int cfg_err_at = 0;   // BUSY cycle carrying PSLVERR, 0 = none

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // APB master model: 0 idle, 1 busy, 2 switch, 3 leaving switch
    int m_state = 0;
    int m_cnt   = 0;
    initial begin
        bus_if.apb_info     = 2'b00;
        bus_if.apb_err_beat = 1'b0;
        forever begin
            @(negedge clk);
            bus_if.apb_err_beat = 1'b0;
            if (!rst_n) begin
                m_state = 0;
                bus_if.apb_info = 2'b00;
            end else begin
                case (m_state)
                    0: if (bus_if.apb_cmd == 2'b01 || bus_if.apb_cmd == 2'b10) begin
                        m_state = 1;
                        m_cnt = 0;
                        bus_if.apb_info = 2'b01;
                    end
                    1: begin
                        m_cnt++;
                        if (m_cnt == cfg_err_at) bus_if.apb_err_beat = 1'b1;
                        if (m_cnt >= cfg_len) begin
                            m_state = 2;
                            bus_if.apb_info = 2'b10;
                        end
                    end
                    2: if (bus_if.apb_cmd == 2'b11) m_state = 3;
                    default: begin
                        m_state = 0;
                        bus_if.apb_info = 2'b00;
                    end
                endcase
            end
        end
    end

    // Monitor / scoreboard
    int  wait_k    = 0;
    bit  in_wait   = 0;
    bit  exp_wd    = 0;
    int  dis_cnt   = 0;
    bit  done_prev = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_wait = 0; exp_wd = 0; dis_cnt = 0; done_prev = 0;
            end else begin
                if (bus_if.rd_grant || bus_if.wr_grant) begin
                    chk("grant_onehot", int'(bus_if.rd_grant & bus_if.wr_grant), 0);
                    chk("grant_vs_done", int'(bus_if.rd_done | bus_if.wr_done), 0);
                    chk("grant_cmd", int'(bus_if.apb_cmd), bus_if.wr_grant ? 2 : 1);
                    if (exp_g.size() == 0) chk("grant_expected", 1, 0);
                    else chk("grant_type", int'(bus_if.wr_grant), exp_g.pop_front());
                    in_wait = 1; wait_k = 0; dis_cnt = 0;
                end else if (in_wait && bus_if.apb_cmd == 2'b00) begin
                    wait_k++;
                    if (wait_k - 1 >= TMO) exp_wd = 1;
                    chk("wd_timeout_wait", int'(bus_if.wd_timeout), int'(exp_wd));
                end
                if (bus_if.apb_cmd == 2'b11) begin
                    in_wait = 0;
                    dis_cnt++;
                end
                if ((bus_if.rd_done || bus_if.wr_done) && !done_prev) begin
                    chk("done_onehot", int'(bus_if.rd_done ^ bus_if.wr_done), 1);
                    if (exp_r.size() == 0) chk("resp_expected", 1, 0);
                    else chk("resp", int'(bus_if.wr_done) * 2 + int'(bus_if.resp_err), exp_r.pop_front());
                    chk("disable_cycles", dis_cnt, 2);
                    chk("wd_timeout_done", int'(bus_if.wd_timeout), int'(exp_wd));
                end
                done_prev = bus_if.rd_done | bus_if.wr_done;
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cmd"}, int'(bus_if.apb_cmd), 0);
        chk({tag, "_flags"}, int'({bus_if.rd_grant, bus_if.wr_grant, bus_if.rd_done,
             bus_if.wr_done, bus_if.resp_err, bus_if.wd_timeout, bus_if.busy}), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.rd_req = 1'b0;
        bus_if.wr_req = 1'b0;
        bus_if.resp_ack = 1'b0;
        exp_g.delete();
        exp_r.delete();
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        #1 rst_n = 1'b1;
    endtask

    // Serve one transaction: wait for grant, optionally drop the granted
    // request, wait for done, hold off ack for ack_delay cycles, then ack.
    task automatic run_one(input bit keep, input int ack_delay, output int lat);
        bit got;
        got = 0;
        lat = -1;
        for (int i = 1; i <= 50 && !got; i++) begin
            @(negedge clk);
            if (bus_if.rd_grant || bus_if.wr_grant) begin
                got = 1;
                lat = i;
            end
        end
        if (!got) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        if (!keep) begin
            if (bus_if.rd_grant) bus_if.rd_req = 1'b0;
            if (bus_if.wr_grant) bus_if.wr_req = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus_if.rd_done || bus_if.wr_done) got = 1;
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            chk("bp_no_grant", int'(bus_if.rd_grant | bus_if.wr_grant), 0);
            chk("bp_cmd_idle", int'(bus_if.apb_cmd), 0);
            chk("bp_done_held", int'(bus_if.rd_done | bus_if.wr_done), 1);
        end
        bus_if.resp_ack = 1'b1;
        @(negedge clk);
        bus_if.resp_ack = 1'b0;
    endtask

    initial begin
        int lat;
        bit got;
        do_reset();

        // Single read
        cfg_len = 4; cfg_err_at = 0;
        exp_g.push_back(0); exp_r.push_back(0);
        bus_if.rd_req = 1'b1;
        run_one(0, 0, lat);
        chk("single_read_latency", lat, 1);

        // Tie after reset: R,W,R,W
        do_reset();
        bus_if.rd_req = 1'b1;
        bus_if.wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g.push_back(i % 2);
            exp_r.push_back((i % 2) * 2);
        end
        for (int i = 0; i < 4; i++) begin
            run_one(1, 0, lat);
            chk("tie_latency", lat, 1);
        end
        bus_if.rd_req = 1'b0;
        bus_if.wr_req = 1'b0;

        // Error on beat 3 of 4, then a clean write back-to-back
        cfg_len = 4; cfg_err_at = 3;
        exp_g.push_back(1); exp_r.push_back(3);
        bus_if.wr_req = 1'b1;
        run_one(0, 0, lat);
        cfg_err_at = 0;
        exp_g.push_back(1); exp_r.push_back(2);
        bus_if.wr_req = 1'b1;
        run_one(0, 0, lat);
        chk("back_to_back_write", lat, 1);

        // Response back-pressure with another write pending
        exp_g.push_back(1); exp_r.push_back(2);
        exp_g.push_back(1); exp_r.push_back(2);
        bus_if.wr_req = 1'b1;
        run_one(1, 10, lat);
        run_one(0, 0, lat);
        chk("grant_after_ack", lat, 1);

        // Watchdog: long BUSY, then a normal transaction with the flag kept
        cfg_len = 20;
        exp_g.push_back(0); exp_r.push_back(0);
        bus_if.rd_req = 1'b1;
        run_one(0, 0, lat);
        chk("wd_after_long", int'(bus_if.wd_timeout), 1);
        cfg_len = 3;
        exp_g.push_back(1); exp_r.push_back(2);
        bus_if.wr_req = 1'b1;
        run_one(0, 0, lat);
        chk("wd_sticky", int'(bus_if.wd_timeout), 1);

        // Reset in the middle of WAIT
        cfg_len = 10;
        exp_g.push_back(0);
        bus_if.rd_req = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus_if.rd_grant) got = 1;
        end
        chk("mid_wait_grant", int'(got), 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        exp_r.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        cfg_len = 3;
        exp_g.push_back(0); exp_r.push_back(0);
        run_one(0, 0, lat);
        chk("post_reset_grant", lat, 1);

        repeat (3) @(negedge clk);
        chk("queues_drained", exp_g.size() + exp_r.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
